pulse_channel_gen: RTL and testbench

Parametrised pulse-wave voice, successor to the fixed 25%-duty channel 2 pulse. It adds the following:
- run-time selectable duty (12.5/25/50/75%), switched glitch-free at phase wrap
- a built-in envelope with a programmable decay period
- a note-off release phase and an activity flag

It sits between a note sequencer, which supplies phase delta, level and duty, and the PWM mixer.

---
 rtl/pulse_pkg.sv | 34 +++
 rtl/pulse_envelope.sv | 93 +++++++++
 rtl/pulse_channel_gen.sv | 90 +++++++++
 tb/tb_pulse_channel_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared types for the pulse channel: duty selection, voice states and
// the pulse-high decode used by the top level.
package pulse_pkg;

  typedef enum logic [1:0] {
    DUTY_12 = 2'b00,
    DUTY_25 = 2'b01,
    DUTY_50 = 2'b10,
    DUTY_75 = 2'b11
  } duty_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PLAY    = 2'b01,
    RELEASE = 2'b10
  } state_t;

  localparam duty_t DUTY_RESET = DUTY_25;

  // Pulse is high in the last fraction of each period, judged from the top 3 phase bits.
  function automatic logic duty_high(input duty_t duty, input logic [2:0] top3);
    logic high;
    high = 1'b0;
    case (duty)
      DUTY_12: high = (top3 == 3'b111);
      DUTY_25: high = (top3[2:1] == 2'b11);
      DUTY_50: high = top3[2];
      DUTY_75: high = (top3[2:1] != 2'b00);
      default: high = 1'b0;
    endcase
    return high;
  endfunction

endpackage

// File: rtl/pulse_envelope.sv
// Voice state machine with the envelope register and decay-tick counter.
// A note load always wins over note-off and tick in the same cycle.
module pulse_envelope
  import pulse_pkg::*;
#(
  parameter int OUT_W   = 9,
  parameter int DECAY_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick_stb,
  input  logic               i_note_stb,
  input  logic               i_note_off,
  input  logic [OUT_W-1:0]   i_level,
  input  logic [DECAY_W-1:0] i_decay_period,
  output logic [OUT_W-1:0]   o_envelope,
  output logic [1:0]         o_state,
  output logic               o_note_load
);

  localparam logic [OUT_W-1:0]   ENV_ONE = OUT_W'(1);
  localparam logic [DECAY_W-1:0] CNT_ONE = DECAY_W'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic [OUT_W-1:0]   r_env;
  logic [OUT_W-1:0]   w_env_next;
  logic [DECAY_W-1:0] r_cnt;
  logic [DECAY_W-1:0] w_cnt_next;
  logic [DECAY_W-1:0] r_decay;
  logic [DECAY_W-1:0] w_decay_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_env   <= '0;
      r_cnt   <= '0;
      r_decay <= '0;
    end else begin
      r_state <= w_state_next;
      r_env   <= w_env_next;
      r_cnt   <= w_cnt_next;
      r_decay <= w_decay_next;
    end
  end

  // An envelope that has reached 0 retires the voice on the following cycle.
  always_comb begin
    w_state_next = r_state;
    w_env_next   = r_env;
    w_cnt_next   = r_cnt;
    w_decay_next = r_decay;
    if (i_note_stb) begin
      w_env_next   = i_level;
      w_cnt_next   = '0;
      w_decay_next = i_decay_period;
      w_state_next = (i_level != '0) ? PLAY : IDLE;
    end else begin
      case (r_state)
        PLAY: begin
          if (r_env == '0) begin
            w_state_next = IDLE;
          end else if (i_note_off) begin
            w_state_next = RELEASE;
            w_cnt_next   = '0;
          end else if (i_tick_stb && (r_decay != '0)) begin
            if (r_cnt == (r_decay - CNT_ONE)) begin
              w_cnt_next = '0;
              w_env_next = r_env - ENV_ONE;
            end else begin
              w_cnt_next = r_cnt + CNT_ONE;
            end
          end
        end
        RELEASE: begin
          if (r_env == '0) begin
            w_state_next = IDLE;
          end else if (i_tick_stb) begin
            w_env_next = r_env - ENV_ONE;
          end
        end
        IDLE: begin
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign o_envelope  = r_env;
  assign o_state     = r_state;
  assign o_note_load = i_note_stb;

endmodule

// File: rtl/pulse_channel_gen.sv
// Pulse-wave voice: phase accumulator, wrap-synchronised duty latch,
// pulse decode and registered output around the envelope sub-module.
module pulse_channel_gen
  import pulse_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 9,
  parameter int DECAY_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick_stb,
  input  logic               i_note_stb,
  input  logic               i_note_off,
  input  logic [PHASE_W-1:0] i_phase_delta,
  input  logic [OUT_W-1:0]   i_level,
  input  logic [DECAY_W-1:0] i_decay_period,
  input  logic [1:0]         i_duty,
  output logic [OUT_W-1:0]   o_output,
  output logic               o_frame_pulse,
  output logic               o_active
);

  logic [OUT_W-1:0]   w_env;
  logic [1:0]         w_state_bits;
  state_t             w_state;
  logic               w_note_load;
  logic [PHASE_W:0]   w_sum;
  logic               w_high;

  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_delta;
  duty_t              r_duty_active;
  duty_t              r_duty_pending;
  logic [OUT_W-1:0]   r_output;
  logic               r_frame;

  pulse_envelope #(
    .OUT_W   (OUT_W),
    .DECAY_W (DECAY_W)
  ) u_envelope (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_tick_stb     (i_tick_stb),
    .i_note_stb     (i_note_stb),
    .i_note_off     (i_note_off),
    .i_level        (i_level),
    .i_decay_period (i_decay_period),
    .o_envelope     (w_env),
    .o_state        (w_state_bits),
    .o_note_load    (w_note_load)
  );

  assign w_state = state_t'(w_state_bits);
  assign w_sum   = {1'b0, r_phase} + {1'b0, r_delta};
  assign w_high  = duty_high(r_duty_active, r_phase[PHASE_W-1 -: 3]);

  // Duty only takes effect at phase wrap so a running pulse is never cut or stretched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase        <= '0;
      r_delta        <= '0;
      r_duty_active  <= DUTY_RESET;
      r_duty_pending <= DUTY_RESET;
      r_output       <= '0;
      r_frame        <= 1'b0;
    end else begin
      r_duty_pending <= duty_t'(i_duty);
      r_output       <= w_high ? w_env : '0;
      r_frame        <= (w_state != IDLE) && r_phase[PHASE_W-1];
      if (w_note_load) begin
        r_phase       <= '0;
        r_delta       <= i_phase_delta;
        r_duty_active <= duty_t'(i_duty);
      end else if (w_state != IDLE) begin
        r_phase <= w_sum[PHASE_W-1:0];
        if (w_sum[PHASE_W]) begin
          r_duty_active <= r_duty_pending;
        end
      end else begin
        r_phase <= '0;
      end
    end
  end

  assign o_output      = r_output;
  assign o_frame_pulse = r_frame;
  assign o_active      = (w_state != IDLE);

endmodule

// File: tb/tb_pulse_channel_gen.sv
// Self-checking bench for pulse_channel_gen: directed scenarios plus a
// randomized run, all compared against an arithmetic model of the voice.
module tb_pulse_channel_gen;

  localparam longint unsigned FULL = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_tick_stb = 1'b0;
  logic        i_note_stb = 1'b0;
  logic        i_note_off = 1'b0;
  logic [31:0] i_phase_delta = '0;
  logic [8:0]  i_level = '0;
  logic [7:0]  i_decay_period = '0;
  logic [1:0]  i_duty = 2'b01;
  logic [8:0]  o_output;
  logic        o_frame_pulse;
  logic        o_active;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  // Reference model: 0 = idle, 1 = play, 2 = release
  longint unsigned mPhase = 0;
  longint unsigned mDelta = 0;
  int mEnv = 0, mCnt = 0, mDecay = 0, mState = 0;
  int mDa = 1, mDp = 1;
  int expOut = 0, expFrame = 0, expActive = 0;

  always #5 clk = ~clk;

  pulse_channel_gen dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_tick_stb     (i_tick_stb),
    .i_note_stb     (i_note_stb),
    .i_note_off     (i_note_off),
    .i_phase_delta  (i_phase_delta),
    .i_level        (i_level),
    .i_decay_period (i_decay_period),
    .i_duty         (i_duty),
    .o_output       (o_output),
    .o_frame_pulse  (o_frame_pulse),
    .o_active       (o_active)
  );

  // Pulse is high for the last duty fraction of the period.
  function automatic bit isHigh(longint unsigned ph, int d);
    case (d)
      0: return ph >= (FULL * 7) / 8;
      1: return ph >= (FULL * 3) / 4;
      2: return ph >= FULL / 2;
      default: return ph >= FULL / 4;
    endcase
  endfunction

  task automatic modelEdge();
    longint unsigned sum;
    int oldDp;
    expOut = 0;
    expFrame = 0;
    if (i_rst) begin
      mPhase = 0; mDelta = 0; mEnv = 0; mCnt = 0; mDecay = 0; mState = 0;
      mDa = 1; mDp = 1;
    end else begin
      expOut = isHigh(mPhase, mDa) ? mEnv : 0;
      expFrame = (mState != 0 && mPhase >= FULL / 2) ? 1 : 0;
      oldDp = mDp;
      mDp = int'(i_duty);
      if (i_note_stb) begin
        mDelta = longint'(i_phase_delta);
        mEnv = int'(i_level);
        mDecay = int'(i_decay_period);
        mCnt = 0;
        mPhase = 0;
        mDa = int'(i_duty);
        mState = (i_level != 0) ? 1 : 0;
      end else begin
        if (mState != 0) begin
          sum = mPhase + mDelta;
          if (sum >= FULL) begin
            sum = sum - FULL;
            mDa = oldDp;
          end
          mPhase = sum;
        end else begin
          mPhase = 0;
        end
        if (mState == 1) begin
          if (mEnv == 0) mState = 0;
          else if (i_note_off) begin
            mState = 2;
            mCnt = 0;
          end else if (i_tick_stb && mDecay != 0) begin
            mCnt = mCnt + 1;
            if (mCnt == mDecay) begin
              mCnt = 0;
              mEnv = mEnv - 1;
            end
          end
        end else if (mState == 2) begin
          if (mEnv == 0) mState = 0;
          else if (i_tick_stb) mEnv = mEnv - 1;
        end
      end
    end
    expActive = (mState != 0) ? 1 : 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock: model and DUT see the same inputs, outputs compared 1 ns later.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("model o_output", 32'(o_output), 32'(expOut));
    checkOutput("model o_frame_pulse", 32'(o_frame_pulse), 32'(expFrame));
    checkOutput("model o_active", 32'(o_active), 32'(expActive));
    i_rst = 1'b0;
    i_note_stb = 1'b0;
    i_note_off = 1'b0;
    i_tick_stb = 1'b0;
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  task automatic countHighs(input int n, output int cnt, output int first);
    cnt = 0;
    first = 0;
    for (int k = 1; k <= n; k++) begin
      applyStimulus();
      if (o_output != 0) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
  endtask

  task automatic loadNote(input logic [31:0] delta, input logic [8:0] level,
                          input logic [7:0] decay, input logic [1:0] duty);
    i_phase_delta = delta;
    i_level = level;
    i_decay_period = decay;
    i_duty = duty;
    i_note_stb = 1'b1;
    applyStimulus();
  endtask

  task automatic tickAfter(input int gap);
    runCycles(gap);
    i_tick_stb = 1'b1;
    applyStimulus();
  endtask

  initial begin
    int cnt, first;
    int sweepDuty[3] = '{0, 2, 3};
    int sweepHigh[3] = '{4, 16, 24};

    // Reset
    i_rst = 1'b1;
    applyStimulus();
    checkOutput("reset o_output", 32'(o_output), 32'd0);
    checkOutput("reset o_frame", 32'(o_frame_pulse), 32'd0);
    checkOutput("reset o_active", 32'(o_active), 32'd0);
    runCycles(2);

    // 1: 25% duty, no decay
    loadNote(32'h1000_0000, 9'h1FF, 8'd0, 2'b01);
    checkOutput("t1 active", 32'(o_active), 32'd1);
    countHighs(32, cnt, first);
    checkOutput("t1 first high", 32'(first), 32'd13);
    checkOutput("t1 high count", 32'(cnt), 32'd8);

    // 2: duty sweep and mid-period change
    for (int d = 0; d < 3; d++) begin
      loadNote(32'h1000_0000, 9'h1FF, 8'd0, 2'(sweepDuty[d]));
      countHighs(32, cnt, first);
      checkOutput("t2 sweep high count", 32'(cnt), 32'(sweepHigh[d]));
    end
    loadNote(32'h1000_0000, 9'h1FF, 8'd0, 2'b00);
    countHighs(4, cnt, first);
    i_duty = 2'b10;
    countHighs(12, cnt, first);
    checkOutput("t2 current period keeps 12.5%", 32'(cnt), 32'd2);
    countHighs(16, cnt, first);
    checkOutput("t2 next period 50%", 32'(cnt), 32'd8);

    // 3: decay 3->0 over six ticks
    loadNote(32'h1000_0000, 9'd3, 8'd2, 2'b11);
    for (int t = 1; t <= 6; t++) tickAfter(9);
    checkOutput("t3 active at env 0", 32'(o_active), 32'd1);
    applyStimulus();
    checkOutput("t3 active falls", 32'(o_active), 32'd0);
    runCycles(5);
    checkOutput("t3 idle output", 32'(o_output), 32'd0);
    checkOutput("t3 idle frame", 32'(o_frame_pulse), 32'd0);

    // 4: release
    loadNote(32'h1000_0000, 9'd5, 8'd0, 2'b11);
    for (int t = 0; t < 5; t++) tickAfter(9);
    checkOutput("t4 sustain active", 32'(o_active), 32'd1);
    i_note_off = 1'b1;
    applyStimulus();
    for (int t = 1; t <= 5; t++) tickAfter(9);
    checkOutput("t4 release env 0 active", 32'(o_active), 32'd1);
    applyStimulus();
    checkOutput("t4 release idle", 32'(o_active), 32'd0);
    i_note_off = 1'b1;
    applyStimulus();
    checkOutput("t4 note_off in idle", 32'(o_active), 32'd0);

    // 5: note_stb + note_off + tick together
    i_note_off = 1'b1;
    i_tick_stb = 1'b1;
    loadNote(32'h1000_0000, 9'd7, 8'd3, 2'b01);
    checkOutput("t5 active", 32'(o_active), 32'd1);
    countHighs(16, cnt, first);
    checkOutput("t5 first high", 32'(first), 32'd13);
    checkOutput("t5 high count", 32'(cnt), 32'd4);
    runCycles(13);
    checkOutput("t5 envelope 7", 32'(o_output), 32'd7);

    // 6: reset mid-pulse, then a zero-level note
    i_rst = 1'b1;
    applyStimulus();
    checkOutput("t6 reset output", 32'(o_output), 32'd0);
    checkOutput("t6 reset frame", 32'(o_frame_pulse), 32'd0);
    checkOutput("t6 reset active", 32'(o_active), 32'd0);
    loadNote(32'h1000_0000, 9'd0, 8'd0, 2'b11);
    checkOutput("t6 level 0 active", 32'(o_active), 32'd0);
    runCycles(20);
    checkOutput("t6 level 0 output", 32'(o_output), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      i_rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) begin
        i_note_stb = 1'b1;
        i_phase_delta = ($urandom_range(0, 1) == 0) ? (32'($urandom_range(1, 16)) << 26) : $urandom;
        i_level = 9'($urandom_range(0, 511));
        i_decay_period = 8'($urandom_range(0, 3));
        i_duty = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 15) == 0) i_duty = 2'($urandom_range(0, 3));
      i_note_off = ($urandom_range(0, 59) == 0);
      i_tick_stb = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
